// File: rtl/level_monitor_seq.sv
// Clocked reservoir level monitor: synchronise, debounce, validate, classify, alarm, 7-seg.
// Optional alarm/display blink selected with `define ALARM_BLINK_EN.
`timescale 1ns/1ps
module level_monitor_seq #(
   parameter int N_SENSORS  = 5,
   parameter int DEB_CYCLES = 4,
   parameter int CRIT_LEVEL = 1,
   parameter int LOW_LEVEL  = 3,
   parameter int BLINK_DIV  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_SENSORS-1:0] sen,
   input  logic                 button0,
   output logic [3:0]           level,
   output logic                 st_crit,
   output logic                 st_low,
   output logic                 st_norm,
   output logic                 st_err,
   output logic                 alarme,
   output logic [6:0]           seg
);

   localparam int NB      = N_SENSORS + 1;
   localparam int STARTUP = DEB_CYCLES + 2;
   localparam logic [3:0] CRIT_L   = 4'(CRIT_LEVEL);
   localparam logic [3:0] LOW_L    = 4'(LOW_LEVEL);
   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   if (N_SENSORS < 2 || N_SENSORS > 15 || DEB_CYCLES < 1 || DEB_CYCLES > 255 ||
       LOW_LEVEL <= CRIT_LEVEL || BLINK_DIV < 1) begin : g_bad_params
      $error("level_monitor_seq: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      QUIET    = 2'd0,
      RING     = 2'd1,
      SILENCED = 2'd2
   } alarm_state_t;

   // bit N_SENSORS of the input path carries the button
   logic [NB-1:0] sync1, sync2, deb;
   logic [7:0]    deb_cnt [NB];
   logic [8:0]    start_cnt;
   logic          running, load_now;

   logic [N_SENSORS-1:0] sen_deb;
   logic [N_SENSORS:0]   sen_ext;
   logic                 btn_deb, btn_prev, btn_edge;
   logic                 valid;
   logic [3:0]           ones;
   logic [6:0]           seg_q;
   logic                 alarm_src;
   alarm_state_t         state;

   assign running  = (start_cnt == 9'(STARTUP));
   assign load_now = (start_cnt == 9'(STARTUP - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {button0, sen};
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         start_cnt <= '0;
      else if (!running)
         start_cnt <= start_cnt + 9'd1;
   end

   // The final startup cycle seeds the debounced vector so no reset-zero alarm appears.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb <= '0;
         for (int unsigned i = 0; i < NB; i++) deb_cnt[i] <= '0;
      end else if (load_now) begin
         deb <= sync2;
         for (int unsigned i = 0; i < NB; i++) deb_cnt[i] <= '0;
      end else if (running) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (sync2[i] != deb[i]) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  deb[i]     <= sync2[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 8'd1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign sen_deb  = deb[N_SENSORS-1:0];
   assign btn_deb  = deb[N_SENSORS];
   assign btn_edge = btn_deb & ~btn_prev;
   assign sen_ext  = {1'b0, sen_deb};
   // Thermometer pattern iff adding one carries cleanly out of the ones run.
   assign valid    = ((sen_ext + {{N_SENSORS{1'b0}}, 1'b1}) & sen_ext) == '0;

   always_comb begin
      ones = '0;
      for (int unsigned i = 0; i < N_SENSORS; i++) ones = ones + 4'(sen_deb[i]);
   end

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0:    return 7'h3F;
         4'h1:    return 7'h06;
         4'h2:    return 7'h5B;
         4'h3:    return 7'h4F;
         4'h4:    return 7'h66;
         4'h5:    return 7'h6D;
         4'h6:    return 7'h7D;
         4'h7:    return 7'h07;
         4'h8:    return 7'h7F;
         4'h9:    return 7'h6F;
         4'hA:    return 7'h77;
         4'hB:    return 7'h7C;
         4'hC:    return 7'h39;
         4'hD:    return 7'h5E;
         4'hE:    return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         level   <= '0;
         st_crit <= 1'b0;
         st_low  <= 1'b0;
         st_norm <= 1'b0;
         st_err  <= 1'b0;
         seg_q   <= '0;
      end else if (running) begin
         if (valid) begin
            level   <= ones;
            st_crit <= (ones < CRIT_L);
            st_low  <= (ones >= CRIT_L) && (ones < LOW_L);
            st_norm <= (ones >= LOW_L);
            st_err  <= 1'b0;
            seg_q   <= hex_seg(ones);
         end else begin
            st_crit <= 1'b0;
            st_low  <= 1'b0;
            st_norm <= 1'b0;
            st_err  <= 1'b1;
            seg_q   <= 7'h40;
         end
      end
   end

   assign alarm_src = st_crit | st_err;

`ifdef ALARM_BLINK_EN
   logic [BLINK_DIV:0] blink_cnt, blink_inc;
   logic               blank;

   assign blink_inc = blink_cnt + {{BLINK_DIV{1'b0}}, 1'b1};
   assign seg       = blank ? '0 : seg_q;
`else
   assign seg = seg_q;
`endif

   // Alarm output is registered alongside the state so it is high exactly in RING.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= QUIET;
         alarme   <= 1'b0;
         btn_prev <= 1'b0;
`ifdef ALARM_BLINK_EN
         blink_cnt <= '0;
         blank     <= 1'b0;
`endif
      end else begin
         btn_prev <= btn_deb;
`ifdef ALARM_BLINK_EN
         blink_cnt <= blink_inc;
         blank     <= 1'b0;
`endif
         case (state)
            QUIET: begin
               if (alarm_src) begin
                  state  <= RING;
                  alarme <= 1'b1;
`ifdef ALARM_BLINK_EN
                  blink_cnt <= '0;
`endif
               end
            end
            RING: begin
               if (btn_edge) begin
                  state  <= SILENCED;
                  alarme <= 1'b0;
               end else begin
`ifdef ALARM_BLINK_EN
                  alarme <= ~blink_inc[BLINK_DIV];
`else
                  alarme <= 1'b1;
`endif
               end
            end
            SILENCED: begin
               if (!alarm_src) begin
                  state <= QUIET;
               end else begin
`ifdef ALARM_BLINK_EN
                  blank <= blink_inc[BLINK_DIV];
`endif
               end
            end
            default: begin
               state  <= QUIET;
               alarme <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_level_monitor_seq.sv
// Directed bench for level_monitor_seq with default parameters (blink feature disabled).
`timescale 1ns/1ps
module tb_level_monitor_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] sen;
   logic       button0;
   logic [3:0] level;
   logic       st_crit, st_low, st_norm, st_err, alarme;
   logic [6:0] seg;

   int checks = 0;
   int errors = 0;

   level_monitor_seq #(
      .N_SENSORS (5),
      .DEB_CYCLES(4),
      .CRIT_LEVEL(1),
      .LOW_LEVEL (3),
      .BLINK_DIV (8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .sen    (sen),
      .button0(button0),
      .level  (level),
      .st_crit(st_crit),
      .st_low (st_low),
      .st_norm(st_norm),
      .st_err (st_err),
      .alarme (alarme),
      .seg    (seg)
   );

   always #5 clk = ~clk;

   // st field order: {crit, low, norm, err}
   typedef struct {
      logic [4:0]  sen;
      logic        btn;
      int unsigned cyc;
      logic [3:0]  level;
      logic [3:0]  st;
      logic        al;
      logic [6:0]  seg;
   } vec_t;

   localparam logic [3:0] S0 = 4'b0000;
   localparam logic [3:0] SC = 4'b1000;
   localparam logic [3:0] SL = 4'b0100;
   localparam logic [3:0] SN = 4'b0010;
   localparam logic [3:0] SE = 4'b0001;

   vec_t vecs[28];

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] e_level, input logic [3:0] e_st,
                        input logic e_al, input logic [6:0] e_seg);
      logic [15:0] got, exp;
      got = {level, st_crit, st_low, st_norm, st_err, alarme, seg};
      exp = {e_level, e_st, e_al, e_seg};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got level=%0d st(c,l,n,e)=%b alarme=%b seg=%h, expected level=%0d st=%b alarme=%b seg=%h",
                  name, level, {st_crit, st_low, st_norm, st_err}, alarme, seg,
                  e_level, e_st, e_al, e_seg);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{5'b00111, 1'b0, 6,  4'd0, S0, 1'b0, 7'h00}; // startup hold
      vecs[1]  = '{5'b00111, 1'b0, 1,  4'd3, SN, 1'b0, 7'h4F}; // first valid
      vecs[2]  = '{5'b00000, 1'b0, 6,  4'd3, SN, 1'b0, 7'h4F}; // latency boundary
      vecs[3]  = '{5'b00000, 1'b0, 1,  4'd0, SC, 1'b0, 7'h3F}; // critical
      vecs[4]  = '{5'b00000, 1'b0, 1,  4'd0, SC, 1'b1, 7'h3F}; // ring one later
      vecs[5]  = '{5'b00000, 1'b1, 10, 4'd0, SC, 1'b0, 7'h3F}; // acknowledged
      vecs[6]  = '{5'b00111, 1'b0, 8,  4'd3, SN, 1'b0, 7'h4F}; // back to normal
      vecs[7]  = '{5'b01111, 1'b0, 6,  4'd3, SN, 1'b0, 7'h4F};
      vecs[8]  = '{5'b01111, 1'b0, 1,  4'd4, SN, 1'b0, 7'h66};
      vecs[9]  = '{5'b11111, 1'b0, 7,  4'd5, SN, 1'b0, 7'h6D}; // all wet
      vecs[10] = '{5'b00101, 1'b0, 7,  4'd5, SE, 1'b0, 7'h40}; // invalid, level held
      vecs[11] = '{5'b00101, 1'b0, 1,  4'd5, SE, 1'b1, 7'h40};
      vecs[12] = '{5'b00011, 1'b0, 7,  4'd2, SL, 1'b1, 7'h5B}; // low, alarm latched
      vecs[13] = '{5'b00011, 1'b0, 5,  4'd2, SL, 1'b1, 7'h5B};
      vecs[14] = '{5'b00011, 1'b1, 6,  4'd2, SL, 1'b1, 7'h5B}; // ack boundary
      vecs[15] = '{5'b00011, 1'b1, 1,  4'd2, SL, 1'b0, 7'h5B};
      vecs[16] = '{5'b00001, 1'b0, 8,  4'd1, SL, 1'b0, 7'h06}; // level == CRIT_LEVEL
      vecs[17] = '{5'b00000, 1'b0, 1,  4'd1, SL, 1'b0, 7'h06}; // button follows one cycle later
      vecs[18] = '{5'b00000, 1'b1, 6,  4'd0, SC, 1'b0, 7'h3F};
      vecs[19] = '{5'b00000, 1'b1, 1,  4'd0, SC, 1'b1, 7'h3F}; // same-cycle edge ignored
      vecs[20] = '{5'b00000, 1'b1, 5,  4'd0, SC, 1'b1, 7'h3F};
      vecs[21] = '{5'b00000, 1'b0, 10, 4'd0, SC, 1'b1, 7'h3F};
      vecs[22] = '{5'b00000, 1'b1, 7,  4'd0, SC, 1'b0, 7'h3F}; // later edge silences
      vecs[23] = '{5'b00000, 1'b0, 8,  4'd0, SC, 1'b0, 7'h3F}; // silenced persists
      vecs[24] = '{5'b00111, 1'b0, 8,  4'd3, SN, 1'b0, 7'h4F};
      vecs[25] = '{5'b10000, 1'b0, 8,  4'd3, SE, 1'b1, 7'h40}; // re-ring after quiet
      vecs[26] = '{5'b10000, 1'b1, 7,  4'd3, SE, 1'b0, 7'h40};
      vecs[27] = '{5'b00111, 1'b0, 8,  4'd3, SN, 1'b0, 7'h4F};

      reset   = 1'b1;
      sen     = 5'b00111;
      button0 = 1'b0;
      tick(3);
      check("reset", 4'd0, S0, 1'b0, 7'h00);
      reset = 1'b0;

      for (int i = 0; i < 28; i++) begin
         sen     = vecs[i].sen;
         button0 = vecs[i].btn;
         tick(vecs[i].cyc);
         check($sformatf("vec%0d", i), vecs[i].level, vecs[i].st, vecs[i].al, vecs[i].seg);
      end

      // 3-cycle glitch must be filtered out entirely
      sen = 5'b01111;
      tick(3);
      sen = 5'b00111;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("glitch3_c%0d", i), 4'd3, SN, 1'b0, 7'h4F);
         tick(1);
      end

      // 4-cycle pulse is just long enough to pass
      sen = 5'b01111;
      tick(4);
      sen = 5'b00111;
      tick(3);
      check("pulse4_seen", 4'd4, SN, 1'b0, 7'h66);
      tick(10);
      check("pulse4_gone", 4'd3, SN, 1'b0, 7'h4F);

      // reset in the middle of RING
      sen = 5'b00000;
      tick(8);
      check("pre_reset_ring", 4'd0, SC, 1'b1, 7'h3F);
      reset = 1'b1;
      tick(1);
      check("mid_reset", 4'd0, S0, 1'b0, 7'h00);
      reset = 1'b0;
      sen   = 5'b00111;
      tick(6);
      check("restart_hold", 4'd0, S0, 1'b0, 7'h00);
      tick(1);
      check("restart_valid", 4'd3, SN, 1'b0, 7'h4F);
      tick(3);
      check("restart_no_alarm", 4'd3, SN, 1'b0, 7'h4F);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/level_monitor_seq.md
Name: level_monitor_seq

Overview:
- Parametrised, clocked successor to the combinational reservoir level monitor.
- Takes N thermometer-coded level sensors plus an operator button.
- Debounces all inputs, validates the sensor pattern and classifies the level as CRITICAL / LOW / NORMAL / ERROR.
- Drives status flags, a latched-and-acknowledgeable alarm and a 7-segment level/status digit; sits between the raw sensor pins and the board display/buzzer.

Parameters:
- N_SENSORS, 5, number of level sensors, 2..15; sen[0] is the lowest.
- DEB_CYCLES, 4, consecutive identical synchronised samples required before a debounced bit changes, 1..255.
- CRIT_LEVEL, 1, level strictly below this value means CRITICAL.
- LOW_LEVEL, 3, level strictly below this value but >= CRIT_LEVEL means LOW; must be > CRIT_LEVEL.
- BLINK_DIV, 8, log2 of the alarm blink half-period in cycles (used only with ALARM_BLINK_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- sen  input  N_SENSORS  raw asynchronous sensor inputs; 1 = water present.
- button0  input  1  raw asynchronous acknowledge button, active-high.
- level  output  4  debounced level, count of wet sensors, 0..N_SENSORS.
- st_crit  output  1  CRITICAL status.
- st_low  output  1  LOW status.
- st_norm  output  1  NORMAL status.
- st_err  output  1  invalid (non-thermometer) sensor pattern.
- alarme  output  1  buzzer/alarm drive.
- seg  output  7  {g,f,e,d,c,b,a}, active-high segments.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs 0, seg = 7'h00, alarm FSM = QUIET, debounce counters 0, startup counter 0.
- Input path: every sen bit and button0 goes through a 2-FF synchroniser, then a per-bit counter debouncer (DEB_CYCLES).
- Startup: for DEB_CYCLES+2 cycles after reset release, outputs hold reset values. On the last cycle the debounced vector loads the synchronised value directly. Status is valid from the next cycle; no spurious alarm from a reset-zero vector.
- Debounce: the counter increments while synchronised != debounced and clears when equal. When the count reaches DEB_CYCLES, the debounced bit flips and the counter clears.
- Latency: a clean input change stable from cycle t is visible on level/st_*/seg at t+2+DEB_CYCLES+1. The alarm reacts one cycle later.
- Validity: the pattern is valid iff it is of the form 0..01..1 (all ones contiguous from bit 0).
  - Invalid: st_err=1, other st_* = 0, level holds its last valid value, seg shows '-' (7'h40).
- Classification, registered and one-hot among st_crit/st_low/st_norm/st_err:
  - level < CRIT_LEVEL: CRITICAL.
  - level < LOW_LEVEL: LOW.
  - otherwise: NORMAL.
- Display: valid pattern shows level as a hex digit, with standard segment codes for 0..F.
- Alarm FSM (QUIET, RING, SILENCED); alarm source = st_crit | st_err.
  - QUIET -> RING when the source is 1.
  - RING -> SILENCED on a debounced button rising edge.
  - RING stays latched even if the source clears; only an acknowledge leaves RING.
  - SILENCED -> QUIET when the source is 0.
  - SILENCED stays while the source persists; a new source after QUIET re-rings.
  - alarme = 1 in RING only.
- Simultaneous events:
  - Button edge in the same cycle the source rises from QUIET: go to RING; the edge is ignored.
  - Button edge in QUIET or SILENCED: no effect.
- Reset mid-operation: immediate return to reset values; startup sequence repeats.

Optional Feature:
- Macro ALARM_BLINK_EN.
- Defined: in RING, alarme toggles every 2^BLINK_DIV cycles from a free-running counter, starting high on RING entry (counter cleared on entry). In SILENCED, seg blinks off/on at the same rate to flag the unresolved condition.
- Undefined: alarme is steady 1 in RING, seg is steady, and no blink counter is synthesised.

Test Plan:
- Reset, then sen=5'b00111 held; DEB_CYCLES=4: outputs 0 for 6 cycles, then level=3, st_norm=1, seg=7'h4F, alarme=0.
- From 00111, step sen to 00000 stable: at t+7, level=0 and st_crit=1, seg=7'h3F. At t+8, alarme=1. Pulse button0 for 10 cycles: alarme=0 (SILENCED). Restore 00111: FSM returns to QUIET, alarme=0.
- From 00111, glitch sen[3] high for 3 cycles: no change on any output. Hold it high for 4+ cycles: level=4 at expected latency.
- sen=5'b00101: st_err=1, seg=7'h40, level holds previous value, alarm rings. Restore 00011: st_low=1. alarme stays 1 until button acknowledge (latched).
- Source rise and button edge in the same cycle: FSM in RING, alarme=1. A later button edge gives SILENCED.
- With ALARM_BLINK_EN and BLINK_DIV=3 in RING: alarme is high for 8 cycles, then low for 8 cycles, repeating. Assert reset mid-RING: next cycle alarme=0 and seg=0.
